// File: rtl/free_list_bank.sv
// One bank of the physical-register free list: a circular FIFO of free PR tags
// preloaded at reset. Optional same-cycle enq->deq bypass: FREE_LIST_BANK_BYPASS_EN.
module free_list_bank #(
  parameter int BANK_ID         = 0,
  parameter int DEPTH           = 32,
  parameter int LOWER_THRESHOLD = 8,
  parameter int UPPER_THRESHOLD = 24,
  parameter int PR_W            = 7,
  parameter int AR_COUNT        = 32,
  parameter int BANK_COUNT      = 4,
  parameter int INIT_COUNT      = 24,
  localparam int PTR_W          = $clog2(DEPTH),
  localparam int CNT_W          = PTR_W + 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             enq_valid,
  input  logic [PR_W-1:0]  enq_PR,
  output logic             deq_valid,
  output logic [PR_W-1:0]  deq_PR,
  input  logic             deq_ready,
  output logic [CNT_W-1:0] count,
  output logic             below_lower,
  output logic             above_upper,
  output logic             overflow_err
);

  logic [PR_W-1:0]  mem [DEPTH];
  logic [PTR_W-1:0] head, tail;
  logic [CNT_W-1:0] count_next;
  logic             empty, full, pop, enq_write, bypass;

  assign empty = (count == '0);
  assign full  = (count == CNT_W'(DEPTH));

`ifdef FREE_LIST_BANK_BYPASS_EN
  // An empty bank forwards the incoming tag; a consumed forward never touches storage.
  assign bypass    = empty & enq_valid & deq_ready;
  assign deq_valid = ~empty | enq_valid;
  assign deq_PR    = empty ? enq_PR : mem[head];
`else
  assign bypass    = 1'b0;
  assign deq_valid = ~empty;
  assign deq_PR    = mem[head];
`endif

  assign pop       = ~empty & deq_ready;
  assign enq_write = enq_valid & ~full & ~bypass;

  assign below_lower = (count < CNT_W'(LOWER_THRESHOLD));
  assign above_upper = (count > CNT_W'(UPPER_THRESHOLD));

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    count_next = count;
    if (enq_write && !pop)
      count_next = count + CNT_W'(1);
    else if (!enq_write && pop)
      count_next = count - CNT_W'(1);
  end

  // NOTE: state uses non-blocking assignments so all flops update from pre-edge values.
  // NOTE: the array is reset as a whole because the reset image is the initial free list itself.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= (i < INIT_COUNT) ? PR_W'(AR_COUNT + i * BANK_COUNT + BANK_ID) : '0;
      head         <= '0;
      tail         <= PTR_W'(INIT_COUNT);
      count        <= CNT_W'(INIT_COUNT);
      overflow_err <= 1'b0;
    end else begin
      if (enq_write) begin
        mem[tail] <= enq_PR;
        tail      <= (tail == PTR_W'(DEPTH - 1)) ? '0 : tail + PTR_W'(1);
      end
      if (pop)
        head <= (head == PTR_W'(DEPTH - 1)) ? '0 : head + PTR_W'(1);
      count <= count_next;
      if (enq_valid && full)
        overflow_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_free_list_bank.sv
// Bench for free_list_bank (BANK_ID=2): queue model checked every negedge, plus
// hand-computed literal expectations for each scenario.
`timescale 1ns/1ps
module tb_free_list_bank;

  localparam int BANK_ID = 2;
  localparam int DEPTH   = 32;
  localparam int PR_W    = 7;

  logic            CLK = 1'b0;
  logic            RST = 1'b0;
  logic            enq_valid = 1'b0;
  logic [PR_W-1:0] enq_PR = '0;
  logic            deq_ready = 1'b0;
  logic            deq_valid;
  logic [PR_W-1:0] deq_PR;
  logic [5:0]      count;
  logic            below_lower, above_upper, overflow_err;

  int n_cmp  = 0;
  int n_fail = 0;

  int model_q[$];
  int popped[$];
  bit model_ovf;

  free_list_bank #(.BANK_ID(BANK_ID)) dut (
    .CLK(CLK), .RST(RST),
    .enq_valid(enq_valid), .enq_PR(enq_PR),
    .deq_valid(deq_valid), .deq_PR(deq_PR), .deq_ready(deq_ready),
    .count(count), .below_lower(below_lower), .above_upper(above_upper),
    .overflow_err(overflow_err)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input int actual, input int expected);
    n_cmp++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, actual, expected);
    end
  endtask

  // Model: a queue of free tags; the reset image is every non-architectural tag of this bank.
  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      model_q.delete();
      for (int i = 0; i < 24; i++) model_q.push_back(32 + 4 * i + BANK_ID);
      model_ovf = 1'b0;
    end else begin
      int  n;
      bit  handed;
      n      = model_q.size();
      handed = 1'b0;
`ifdef FREE_LIST_BANK_BYPASS_EN
      handed = (n == 0) && enq_valid && deq_ready;
`endif
      if (handed) begin
        popped.push_back(int'(enq_PR));
      end else begin
        if (deq_ready && n > 0) popped.push_back(model_q.pop_front());
        if (enq_valid) begin
          if (n < DEPTH) model_q.push_back(int'(enq_PR));
          else           model_ovf = 1'b1;
        end
      end
    end
  end

  always @(negedge CLK) begin
    int n;
    bit exp_valid;
    int exp_pr;
    n         = model_q.size();
    exp_valid = (n != 0);
    exp_pr    = (n != 0) ? model_q[0] : 0;
`ifdef FREE_LIST_BANK_BYPASS_EN
    if (n == 0 && enq_valid) begin
      exp_valid = 1'b1;
      exp_pr    = int'(enq_PR);
    end
`endif
    check("deq_valid", int'(deq_valid), int'(exp_valid));
    if (exp_valid) check("deq_PR", int'(deq_PR), exp_pr);
    check("count", int'(count), n);
    check("below_lower", int'(below_lower), int'(n < 8));
    check("above_upper", int'(above_upper), int'(n > 24));
    check("overflow_err", int'(overflow_err), int'(model_ovf));
  end

  // Apply inputs for one cycle, then land 1ns after the capturing edge.
  task automatic cyc(input bit ev, input int pr, input bit dr);
    enq_valid = ev;
    enq_PR    = PR_W'(pr);
    deq_ready = dr;
    @(posedge CLK);
    #1;
    enq_valid = 1'b0;
    deq_ready = 1'b0;
  endtask

  task automatic pulse_reset();
    RST = 1'b1;
    @(posedge CLK);
    #1;
    RST = 1'b0;
  endtask

  task automatic check_reset_image(input string tag);
    check({tag, "_deq_valid"}, int'(deq_valid), 1);
    check({tag, "_deq_PR"}, int'(deq_PR), 34);
    check({tag, "_count"}, int'(count), 24);
    check({tag, "_below"}, int'(below_lower), 0);
    check({tag, "_above"}, int'(above_upper), 0);
    check({tag, "_ovf"}, int'(overflow_err), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int has_two;
    #2 RST = 1'b1;
    @(posedge CLK);
    @(posedge CLK);
    #1 RST = 1'b0;
    check_reset_image("reset");

    // Drain the preloaded 24 tags.
    popped.delete();
    repeat (24) cyc(1'b0, 0, 1'b1);
    check("drain_count", int'(count), 0);
    check("drain_valid", int'(deq_valid), 0);
    check("drain_below", int'(below_lower), 1);
    check("drain_size", popped.size(), 24);
    for (int i = 0; i < popped.size(); i++)
      check("drain_order", popped[i], 34 + 4 * i);

    // Empty bank: enqueue 6 then 10, then pop both.
    enq_valid = 1'b1; enq_PR = 7'd6; deq_ready = 1'b0;
    #1;
`ifdef FREE_LIST_BANK_BYPASS_EN
    check("enq6_same_cycle_valid", int'(deq_valid), 1);
`else
    check("enq6_same_cycle_valid", int'(deq_valid), 0);
`endif
    @(posedge CLK); #1;
    check("enq6_count", int'(count), 1);
    check("enq6_next_valid", int'(deq_valid), 1);
    check("enq6_head", int'(deq_PR), 6);
    cyc(1'b1, 10, 1'b0);
    check("enq10_count", int'(count), 2);
    popped.delete();
    cyc(1'b0, 0, 1'b1);
    check("pop1_count", int'(count), 1);
    check("pop1_head", int'(deq_PR), 10);
    cyc(1'b0, 0, 1'b1);
    check("pop2_count", int'(count), 0);
    check("pop_seq0", popped[0], 6);
    check("pop_seq1", popped[1], 10);

    // Fill to full, then overflow with tag 2.
    pulse_reset();
    for (int k = 0; k < 8; k++) cyc(1'b1, 6 + 4 * k, 1'b0);
    check("full_count", int'(count), 32);
    check("full_above", int'(above_upper), 1);
    check("full_ovf_clear", int'(overflow_err), 0);
    cyc(1'b1, 2, 1'b0);
    check("ovf_count", int'(count), 32);
    check("ovf_flag", int'(overflow_err), 1);
    popped.delete();
    repeat (32) cyc(1'b0, 0, 1'b1);
    check("ovf_drain_size", popped.size(), 32);
    check("ovf_drain_24", popped[24], 6);
    check("ovf_drain_31", popped[31], 34);
    has_two = 0;
    foreach (popped[i]) if (popped[i] == 2) has_two++;
    check("ovf_dropped_absent", has_two, 0);
    check("ovf_sticky", int'(overflow_err), 1);

    // Steady state at count=5 with enq+deq every cycle, wrapping both pointers.
    pulse_reset();
    check("reset_clears_ovf", int'(overflow_err), 0);
    popped.delete();
    repeat (19) cyc(1'b0, 0, 1'b1);
    check("steady_start", int'(count), 5);
    for (int i = 0; i < 40; i++) begin
      cyc(1'b1, 2 + 4 * (i % 32), 1'b1);
      check("steady_count", int'(count), 5);
    end
    check("steady_pops", popped.size(), 59);
    check("steady_pop23", popped[23], 126);
    check("steady_pop24", popped[24], 2);
    check("steady_pop58", popped[58], 10);

    // Asynchronous reset mid-stream at count=13 with an enqueue in flight.
    pulse_reset();
    repeat (11) cyc(1'b0, 0, 1'b1);
    check("pre_rst_count", int'(count), 13);
    enq_valid = 1'b1; enq_PR = 7'd2; deq_ready = 1'b0;
    #2 RST = 1'b1;
    #1 check_reset_image("async_rst");
    @(posedge CLK); #1;
    enq_valid = 1'b0;
    RST = 1'b0;
    check_reset_image("post_rst");
    popped.delete();
    repeat (24) cyc(1'b0, 0, 1'b1);
    check("post_rst_first", popped[0], 34);
    has_two = 0;
    foreach (popped[i]) if (popped[i] == 2) has_two++;
    check("rst_enq_absent", has_two, 0);
    check("post_rst_empty", int'(count), 0);

    // Empty bank, enqueue 14 with deq_ready high.
    popped.delete();
    enq_valid = 1'b1; enq_PR = 7'd14; deq_ready = 1'b1;
    #1;
`ifdef FREE_LIST_BANK_BYPASS_EN
    check("byp_valid", int'(deq_valid), 1);
    check("byp_PR", int'(deq_PR), 14);
    @(posedge CLK); #1;
    enq_valid = 1'b0; deq_ready = 1'b0;
    check("byp_count", int'(count), 0);
    check("byp_handed", popped.size(), 1);
`else
    check("nobyp_valid", int'(deq_valid), 0);
    @(posedge CLK); #1;
    enq_valid = 1'b0; deq_ready = 1'b0;
    check("nobyp_count", int'(count), 1);
    check("nobyp_PR", int'(deq_PR), 14);
    cyc(1'b0, 0, 1'b1);
    check("nobyp_count2", int'(count), 0);
`endif
    check("byp_tag", popped[popped.size() - 1], 14);

    repeat (2) @(posedge CLK);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/free_list_bank.md
Name: free_list_bank

Overview:
- One bank of the physical-register free list. It is the reader/writer pair for PR tags.
- Commit releases freed PR tags into the bank through the enqueue port. Rename pops free PR tags through the dequeue port for new destinations.
- One instance per PRF bank (FREE_LIST_BANK_COUNT = 4). Bank b holds only the PRs with PR mod 4 == b.
- Occupancy threshold flags drive rename-side bank steering.

Parameters:
- BANK_ID, 0, index of this bank, 0..FREE_LIST_BANK_COUNT-1.
- DEPTH, FREE_LIST_LENGTH_PER_BANK (32), entry capacity.
- LOWER_THRESHOLD, FREE_LIST_LOWER_THRESHOLD (8), low-occupancy flag level.
- UPPER_THRESHOLD, FREE_LIST_UPPER_THRESHOLD (24), high-occupancy flag level.

Ports:
- CLK  in  1  clock.
- RST  in  1  asynchronous, active-high reset.
- enq_valid  in  1  freed PR tag present this cycle.
- enq_PR  in  LOG_PR_COUNT  freed PR tag; bits [1:0] must equal BANK_ID.
- deq_valid  out  1  a free PR tag is available.
- deq_PR  out  LOG_PR_COUNT  PR tag at the head.
- deq_ready  in  1  rename consumes the head this cycle.
- count  out  LOG_FREE_LIST_LENGTH_PER_BANK+1  current occupancy.
- below_lower  out  1  count < LOWER_THRESHOLD.
- above_upper  out  1  count > UPPER_THRESHOLD.
- overflow_err  out  1  sticky: enqueue attempted while full.

Behaviour:
- Storage: DEPTH-entry circular array. Head and tail pointers are LOG_FREE_LIST_LENGTH_PER_BANK bits wide and wrap modulo DEPTH.
- count is a separate register, range 0..DEPTH.
- Reset (async, RST=1):
  - entry i = (AR_COUNT + i*FREE_LIST_BANK_COUNT + BANK_ID) for i in 0..23, i.e. every bank PR not initially mapped to an architectural register.
  - head=0, tail=24, count=24.
  - Remaining entries are don't-care.
  - overflow_err=0.
  - Resulting outputs: deq_valid=1, deq_PR=AR_COUNT+BANK_ID, below_lower=0, above_upper=0.
- Reset mid-operation: all state returns to the reset image immediately. Any in-flight enqueue is discarded.
- Dequeue:
  - deq_valid = (count != 0).
  - deq_PR = array[head], read combinationally from registered state.
  - A handshake occurs when deq_valid & deq_ready; head advances by 1 at the clock edge.
  - deq_ready while deq_valid=0 is ignored.
  - deq_PR is held stable while deq_valid=1 and deq_ready=0.
- Enqueue:
  - When enq_valid and count<DEPTH: write array[tail]=enq_PR, tail advances by 1.
  - When enq_valid and count==DEPTH: write dropped, pointers unchanged, overflow_err set (cleared only by reset).
- count update:
  - count_next = count + enq_accept - deq_accept.
  - Simultaneous enq+deq leaves count unchanged; both pointers advance.
  - When full: simultaneous enq+deq is NOT accepted for the enqueue (full is evaluated on registered count). Overflow is flagged.
- Empty with enq_valid: the tag is written; deq_valid rises the next cycle. Enqueue-to-dequeue latency is 1 cycle.
- Wrap: pointers roll from DEPTH-1 to 0 with no bubble.
- below_lower, above_upper: combinational from registered count.
- Ordering: strict FIFO.

Optional Feature:
- FREE_LIST_BANK_BYPASS_EN defined:
  - When count==0 and enq_valid=1, deq_valid=1 and deq_PR=enq_PR in the same cycle.
  - If deq_ready is also 1, the tag is handed straight to rename and not written. Tail and count are unchanged.
  - If deq_ready is 0, normal enqueue.
- FREE_LIST_BANK_BYPASS_EN undefined: no combinational path from enq_* to deq_*; enqueue-to-dequeue latency is 1 cycle as above.

Test Plan:
- Reset, BANK_ID=2: deq_valid=1, deq_PR=34, count=24. Pop with deq_ready=1 for 24 cycles -> tags 34,38,...,126 in order; then deq_valid=0, count=0, below_lower=1.
- From empty, enq 6 then 10 on consecutive cycles -> deq_valid=0 in the enq-of-6 cycle, 1 the next cycle. Pops return 6 then 10; count goes 0,1,2,1,0.
- From count=24, enqueue 8 tags -> count=32, above_upper=1. A 9th enqueue of tag 2 -> count stays 32, overflow_err=1; the popped sequence never contains the dropped tag.
- Simultaneous enq+deq every cycle for 40 cycles starting at count=5 -> count stays 5, head/tail wrap past 31->0, FIFO order preserved.
- Assert RST mid-stream at count=13 with enq_valid=1 -> outputs return to the reset image asynchronously; the enqueued tag is absent.
- FREE_LIST_BANK_BYPASS_EN: empty, enq_valid=1 enq_PR=14, deq_ready=1 -> same-cycle deq_valid=1, deq_PR=14; next cycle count=0. Without the macro -> deq_valid=0 that cycle, and 14 is popped next cycle.
